// File: rtl/fft_twiddle_fetch_if.sv
// Twiddle fetch bus: start/status, LUT address/data port and twiddle valid/ready stream.
// Latency: none (wires only).
// Backpressure: tw_ready from the butterfly side stalls the fetch engine while tw_valid is high.
interface fft_twiddle_fetch_if #(
   parameter int N_LOG2 = 9,
   parameter int AW     = 10,
   parameter int DW     = 18
);
   // Control / status
   logic                     start;
   logic                     busy;
   logic                     done;
   // LUT port
   logic [AW-1:0]            addr;
   logic signed [DW-1:0]     Dout;
   // Twiddle stream
   logic signed [DW-1:0]     tw_re;
   logic signed [DW-1:0]     tw_im;
   logic [3:0]               tw_stage;
   logic [N_LOG2-2:0]        tw_bfly;
   logic                     tw_last;
   logic                     tw_valid;
   logic                     tw_ready;

   // Fetch engine side
   modport master (
      input  start, Dout, tw_ready,
      output busy, done, addr, tw_re, tw_im, tw_stage, tw_bfly, tw_last, tw_valid
   );

   // Environment side (sequencer, LUT, butterfly datapath)
   modport slave (
      output start, Dout, tw_ready,
      input  busy, done, addr, tw_re, tw_im, tw_stage, tw_bfly, tw_last, tw_valid
   );
endinterface

// File: rtl/fft_twiddle_fetch.sv
// Twiddle fetch: sweeps every radix-2 DIF stage/butterfly, reads cos LUT twice per twiddle.
// Latency: start -> first tw_valid in 3+LUT_LAT cycles; one twiddle per 3+LUT_LAT cycles.
// Backpressure: holds tw_* stable in PRESENT until tw_valid && tw_ready; no fetch-ahead.
// Optional feature: define TW_FETCH_CONJ_EN for conjugate (inverse FFT) twiddles.
module fft_twiddle_fetch #(
   parameter int N_LOG2  = 9,
   parameter int AW      = 10,
   parameter int DW      = 18,
   parameter int LUT_LAT = 1
) (
   input  logic                   Clk,
   input  logic                   reset,
   fft_twiddle_fetch_if.master    bus
);

   localparam int N  = 1 << N_LOG2;
   localparam int BW = N_LOG2 - 1;

   // Imaginary part comes from the same cos table shifted by a quarter (or three
   // quarters) turn: cos(x + pi/2) = -sin(x), cos(x + 3pi/2) = +sin(x).
`ifdef TW_FETCH_CONJ_EN
   localparam logic [N_LOG2-1:0] IM_OFFSET = N_LOG2'((3 * N) / 4);
`else
   localparam logic [N_LOG2-1:0] IM_OFFSET = N_LOG2'(N / 4);
`endif

   localparam logic [3:0] LAST_STAGE = 4'(N_LOG2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_RE,
      ISSUE_IM,
      WAIT,
      PRESENT
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_stage;
   logic [3:0]            w_stage_nxt;
   logic [BW-1:0]         r_bfly;
   logic [BW-1:0]         w_bfly_nxt;
   logic [AW-1:0]         r_addr;
   logic [AW-1:0]         w_addr_nxt;
   logic signed [DW-1:0]  r_tw_re;
   logic signed [DW-1:0]  r_tw_im;
   logic                  r_done;
   logic                  w_done_nxt;
   logic [LUT_LAT-1:0]    r_re_pipe;
   logic [LUT_LAT-1:0]    r_im_pipe;

   logic                  w_hs;
   logic                  w_last;
   logic                  w_re_cap;
   logic                  w_im_cap;
   logic [N_LOG2-1:0]     w_k;
   logic [N_LOG2-1:0]     w_k_nxt;
   logic [N_LOG2-1:0]     w_im_addr;

   // Twiddle exponent: (b mod (N/2 >> s)) << s is the same as (b << s) truncated
   // to N_LOG2-1 bits, so a plain shift with natural overflow does the job.
   function automatic logic [N_LOG2-1:0] calc_k(input logic [3:0] s, input logic [BW-1:0] b);
      logic [BW-1:0] sh;
      sh = b << s;
      return {1'b0, sh};
   endfunction

   assign w_k       = calc_k(r_stage, r_bfly);
   assign w_k_nxt   = calc_k(w_stage_nxt, w_bfly_nxt);
   assign w_im_addr = w_k + IM_OFFSET;   // wraps mod N in N_LOG2 bits

   assign w_hs     = (r_state == PRESENT) && bus.tw_ready;
   assign w_last   = (r_stage == LAST_STAGE) && (&r_bfly);

   // Data for an address issued in cycle c is on Dout during cycle c+LUT_LAT.
   assign w_re_cap = r_re_pipe[LUT_LAT-1];
   assign w_im_cap = r_im_pipe[LUT_LAT-1];

   // State register and sweep counters
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_stage <= '0;
         r_bfly  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_stage <= w_stage_nxt;
         r_bfly  <= w_bfly_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state, counter advance and done generation
   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      w_bfly_nxt  = r_bfly;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            // A start coinciding with the done pulse is dropped on purpose.
            if (bus.start && !r_done) begin
               w_state_nxt = ISSUE_RE;
               w_stage_nxt = '0;
               w_bfly_nxt  = '0;
            end
         end
         ISSUE_RE: w_state_nxt = ISSUE_IM;
         ISSUE_IM: w_state_nxt = WAIT;
         WAIT: begin
            if (w_im_cap) begin
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (w_hs) begin
               if (w_last) begin
                  w_state_nxt = IDLE;
                  w_stage_nxt = '0;
                  w_bfly_nxt  = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ISSUE_RE;
                  w_bfly_nxt  = r_bfly + 1'b1;
                  if (&r_bfly) begin
                     w_stage_nxt = r_stage + 4'd1;
                  end
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address is registered so it is valid for the whole ISSUE cycle; it is
   // loaded with the value of the state being entered and otherwise held.
   always_comb begin
      w_addr_nxt = r_addr;
      if (w_state_nxt == ISSUE_RE) begin
         w_addr_nxt = AW'(w_k_nxt);
      end else if (w_state_nxt == ISSUE_IM) begin
         w_addr_nxt = AW'(w_im_addr);
      end
   end

   // LUT address register
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_addr <= '0;
      end else begin
         r_addr <= w_addr_nxt;
      end
   end

   // Issue markers delayed by the LUT read latency to time the data captures
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_re_pipe <= '0;
         r_im_pipe <= '0;
      end else begin
         r_re_pipe[0] <= (r_state == ISSUE_RE);
         r_im_pipe[0] <= (r_state == ISSUE_IM);
         for (int i = 1; i < LUT_LAT; i++) begin
            r_re_pipe[i] <= r_re_pipe[i-1];
            r_im_pipe[i] <= r_im_pipe[i-1];
         end
      end
   end

   // Capture real and imaginary parts from the shared LUT data port
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_tw_re <= '0;
         r_tw_im <= '0;
      end else begin
         if (w_re_cap) begin
            r_tw_re <= bus.Dout;
         end
         if (w_im_cap) begin
            r_tw_im <= bus.Dout;
         end
      end
   end

   assign bus.addr     = r_addr;
   assign bus.tw_re    = r_tw_re;
   assign bus.tw_im    = r_tw_im;
   assign bus.tw_stage = r_stage;
   assign bus.tw_bfly  = r_bfly;
   assign bus.tw_valid = (r_state == PRESENT);
   assign bus.tw_last  = (r_state == PRESENT) && w_last;
   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = r_done;

endmodule

// File: tb/tb_fft_twiddle_fetch.sv
// Self-checking bench for fft_twiddle_fetch with a ramp LUT (Dout = address).
// Latency: LUT model adds LUT_LAT registered cycles.
// Backpressure: tw_ready driven high or randomly stalled by the stimulus.
module tb_fft_twiddle_fetch;

   localparam int N_LOG2  = 9;
   localparam int AW      = 10;
   localparam int DW      = 18;
   localparam int LUT_LAT = 1;
   localparam int N       = 1 << N_LOG2;
   localparam int HALF    = N / 2;
   localparam int TOTAL   = N_LOG2 * HALF;
   localparam int TW_GAP  = 3 + LUT_LAT;
`ifdef TW_FETCH_CONJ_EN
   localparam int IM_SHIFT = N / 2;
`else
   localparam int IM_SHIFT = 0;
`endif

   typedef struct packed {
      logic [DW-1:0]     re;
      logic [DW-1:0]     im;
      logic [3:0]        st;
      logic [N_LOG2-2:0] bf;
      logic              last;
   } tw_rec_t;

   typedef struct {
      int s;
      int b;
      int re;
      int im_fwd;
   } vec_t;

   logic Clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 Clk = ~Clk;

   fft_twiddle_fetch_if #(.N_LOG2(N_LOG2), .AW(AW), .DW(DW)) tw_if ();

   fft_twiddle_fetch #(
      .N_LOG2 (N_LOG2),
      .AW     (AW),
      .DW     (DW),
      .LUT_LAT(LUT_LAT)
   ) dut (
      .Clk  (Clk),
      .reset(reset),
      .bus  (tw_if.master)
   );

   // Ramp LUT with LUT_LAT registered stages
   logic [DW-1:0] lut_pipe [LUT_LAT];
   always @(posedge Clk) begin
      lut_pipe[0] <= DW'(tw_if.addr);
      for (int i = 1; i < LUT_LAT; i++) lut_pipe[i] <= lut_pipe[i-1];
   end
   assign tw_if.Dout = lut_pipe[LUT_LAT-1];

   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor: records handshakes, done pulses and stall-stability violations
   tw_rec_t q_tw [$];
   int      q_cyc [$];
   int      done_cnt  = 0;
   int      done_cyc  = -1;
   logic    done_busy = 1'b0;
   int      stall_err = 0;
   int      stall_cyc = 0;
   logic    prev_stall = 1'b0;
   tw_rec_t held;
   always @(negedge Clk) begin
      tw_rec_t cur;
      cur = {tw_if.tw_re, tw_if.tw_im, tw_if.tw_stage, tw_if.tw_bfly, tw_if.tw_last};
      if (prev_stall && (!tw_if.tw_valid || cur != held)) stall_err++;
      if (tw_if.tw_valid && !tw_if.tw_ready) stall_cyc++;
      if (tw_if.tw_valid && tw_if.tw_ready) begin
         q_tw.push_back(cur);
         q_cyc.push_back(cyc);
      end
      if (tw_if.done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_busy = tw_if.busy;
      end
      prev_stall = tw_if.tw_valid && !tw_if.tw_ready;
      held = cur;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle(input string pfx);
      check({pfx, "_addr"},     64'(tw_if.addr),     0);
      check({pfx, "_tw_re"},    64'(tw_if.tw_re),    0);
      check({pfx, "_tw_im"},    64'(tw_if.tw_im),    0);
      check({pfx, "_tw_stage"}, 64'(tw_if.tw_stage), 0);
      check({pfx, "_tw_bfly"},  64'(tw_if.tw_bfly),  0);
      check({pfx, "_tw_last"},  64'(tw_if.tw_last),  0);
      check({pfx, "_tw_valid"}, 64'(tw_if.tw_valid), 0);
      check({pfx, "_busy"},     64'(tw_if.busy),     0);
      check({pfx, "_done"},     64'(tw_if.done),     0);
   endtask

   // Runs until done is seen (or the budget expires); leaves caller at a negedge.
   task automatic run_until_done(input bit stall, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clk); #1;
         tw_if.tw_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge Clk);
         if (tw_if.done) begin
            ok = 1'b1;
            break;
         end
      end
      tw_if.tw_ready = 1'b1;
   endtask

   task automatic wait_count(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk); #1;
         if (q_tw.size() >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   vec_t    vecs [10];
   tw_rec_t ref_tw [$];

   initial begin
      int  base, st_cyc, bad, d0, n;
      bit  ok;

      vecs[0] = '{0,   0,   0, 128};
      vecs[1] = '{0,   3,   3, 131};
      vecs[2] = '{0, 255, 255, 383};
      vecs[3] = '{1, 130,   4, 132};
      vecs[4] = '{1, 127, 254, 382};
      vecs[5] = '{2, 100, 144, 272};
      vecs[6] = '{4,  17,  16, 144};
      vecs[7] = '{7,   3, 128, 256};
      vecs[8] = '{8,   0,   0, 128};
      vecs[9] = '{8, 255,   0, 128};

      tw_if.start    = 1'b0;
      tw_if.tw_ready = 1'b0;

      // Reset values
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check_idle("rst");
      @(posedge Clk); #1;
      reset = 1'b0;
      tw_if.tw_ready = 1'b1;
      repeat (3) @(negedge Clk);
      check("ready_idle_valid", 64'(tw_if.tw_valid), 0);
      check("ready_idle_busy",  64'(tw_if.busy),     0);

      // Full unstalled sweep
      base = q_tw.size();
      @(posedge Clk); #1;
      tw_if.start = 1'b1;
      st_cyc = cyc;
      @(negedge Clk);
      check("busy_start_cycle", 64'(tw_if.busy), 0);
      @(posedge Clk); #1;
      tw_if.start = 1'b0;
      @(negedge Clk);
      check("busy_after_start", 64'(tw_if.busy), 1);
      run_until_done(1'b0, TOTAL * TW_GAP + 100, ok);
      check("sweep1_done_seen", 64'(ok), 1);
      // start during the done cycle must be ignored
      tw_if.start = 1'b1;
      @(posedge Clk); #1;
      tw_if.start = 1'b0;
      n = q_tw.size() - base;
      check("sweep1_count", 64'(n), 64'(TOTAL));
      if (n > 0) begin
         check("first_latency", 64'(q_cyc[base] - st_cyc), 64'(TW_GAP));
         bad = 0;
         for (int i = 1; i < n; i++)
            if (q_cyc[base+i] - q_cyc[base+i-1] != TW_GAP) bad++;
         check("tw_spacing_bad", 64'(bad), 0);
         bad = 0;
         for (int i = 0; i < n; i++)
            if (q_tw[base+i].last != (i == TOTAL - 1)) bad++;
         check("tw_last_bad", 64'(bad), 0);
         check("done_delay", 64'(done_cyc - q_cyc[base+n-1]), 1);
         check("done_busy_low", 64'(done_busy), 0);
      end
      foreach (vecs[v]) begin
         int idx, exp_im;
         idx    = vecs[v].s * HALF + vecs[v].b;
         exp_im = (vecs[v].im_fwd + IM_SHIFT) % N;
         if (idx < n) begin
            check($sformatf("vec%0d_re", v),    64'(q_tw[base+idx].re), 64'(vecs[v].re));
            check($sformatf("vec%0d_im", v),    64'(q_tw[base+idx].im), 64'(exp_im));
            check($sformatf("vec%0d_stage", v), 64'(q_tw[base+idx].st), 64'(vecs[v].s));
            check($sformatf("vec%0d_bfly", v),  64'(q_tw[base+idx].bf), 64'(vecs[v].b));
         end else begin
            check($sformatf("vec%0d_present", v), 64'(idx < n), 1);
         end
      end
      for (int i = 0; i < n; i++) ref_tw.push_back(q_tw[base+i]);
      repeat (3) @(negedge Clk);
      check("done_cycle_start_ignored", 64'(tw_if.busy), 0);

      // Stalled sweep must reproduce the same sequence
      base = q_tw.size();
      d0   = stall_err;
      bad  = stall_cyc;
      @(posedge Clk); #1;
      tw_if.start = 1'b1;
      @(posedge Clk); #1;
      tw_if.start = 1'b0;
      run_until_done(1'b1, 3 * TOTAL * TW_GAP + 100, ok);
      check("sweep2_done_seen", 64'(ok), 1);
      #1;
      n = q_tw.size() - base;
      check("sweep2_count", 64'(n), 64'(TOTAL));
      check("stalls_exercised", 64'(stall_cyc > bad), 1);
      check("stall_stability_err", 64'(stall_err - d0), 0);
      bad = 0;
      for (int i = 0; i < n && i < ref_tw.size(); i++)
         if (q_tw[base+i] != ref_tw[i]) bad++;
      check("stalled_seq_mismatch", 64'(bad), 0);

      // Reset in the middle of stage 3
      @(posedge Clk); #1;
      tw_if.start = 1'b1;
      @(posedge Clk); #1;
      tw_if.start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 4 * HALF * TW_GAP + 100; i++) begin
         @(negedge Clk);
         if (tw_if.tw_valid && tw_if.tw_stage == 4'd3) begin
            ok = 1'b1;
            break;
         end
      end
      check("reach_stage3", 64'(ok), 1);
      #2 reset = 1'b1;
      #1 check_idle("midrst");
      d0 = done_cnt;
      @(posedge Clk);
      @(posedge Clk); #1;
      reset = 1'b0;
      repeat (20) @(negedge Clk);
      check("no_done_after_abort", 64'(done_cnt - d0), 0);

      // Restart from s=0,b=0; a start pulsed mid-sweep is ignored
      base = q_tw.size();
      @(posedge Clk); #1;
      tw_if.start = 1'b1;
      st_cyc = cyc;
      @(posedge Clk); #1;
      tw_if.start = 1'b0;
      wait_count(base + 3, 20 * TW_GAP, ok);
      check("restart_progress", 64'(ok), 1);
      @(posedge Clk); #1;
      tw_if.start = 1'b1;
      @(posedge Clk); #1;
      tw_if.start = 1'b0;
      wait_count(base + 10, 20 * TW_GAP, ok);
      check("restart_ten", 64'(ok), 1);
      n = q_tw.size() - base;
      if (n > 0) begin
         check("restart_latency", 64'(q_cyc[base] - st_cyc), 64'(TW_GAP));
         check("restart_re0", 64'(q_tw[base].re), 0);
         check("restart_im0", 64'(q_tw[base].im), 64'((128 + IM_SHIFT) % N));
      end
      bad = 0;
      for (int i = 0; i < n && i < 10; i++)
         if (q_tw[base+i].st != 0 || q_tw[base+i].bf != i || q_tw[base+i].re != i ||
             q_tw[base+i].im != (i + 128 + IM_SHIFT) % N) bad++;
      check("ignored_start_seq_bad", 64'(bad), 0);
      check("busy_mid_sweep", 64'(tw_if.busy), 1);

      reset = 1'b1;
      repeat (2) @(posedge Clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fft_twiddle_fetch.md
Name: fft_twiddle_fetch

Overview:
- Address-side initiator for the 512-point cosine LUT (COS_LUT_512Points).
- Walks every radix-2 DIF stage/butterfly of a 2^N_LOG2-point FFT and drives the LUT address port.
- Captures LUT data after its fixed read latency and presents complex twiddles W^k = cos(2πk/N) − j·sin(2πk/N) to the butterfly datapath over a valid/ready handshake.
- One LUT port is time-shared: real part at address k, imaginary part at address (k + N/4) mod N.

Parameters:
- N_LOG2, 9: FFT size N = 2^N_LOG2; stages = N_LOG2; butterflies per stage = N/2.
- AW, 10: LUT address width; indices zero-extended to AW.
- DW, 18: LUT data / twiddle component width, signed.
- LUT_LAT, 1: LUT read latency in clocks, ≥1.

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs to reset values.
- start  in  1  one-cycle pulse; begins a full twiddle sweep. Ignored while busy.
- addr  out  AW  LUT address; drives the LUT addr input.
- Dout  in  DW  LUT read data, valid LUT_LAT cycles after addr.
- tw_re  out  DW  twiddle real part.
- tw_im  out  DW  twiddle imaginary part.
- tw_stage  out  4  stage index of the presented twiddle.
- tw_bfly  out  N_LOG2-1  butterfly index within the stage.
- tw_last  out  1  high with tw_valid for the final twiddle of the sweep.
- tw_valid  out  1  twiddle output valid.
- tw_ready  in  1  downstream accepts when tw_valid && tw_ready.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset values: addr=0, tw_re=0, tw_im=0, tw_stage=0, tw_bfly=0, tw_last=0, tw_valid=0, busy=0, done=0; FSM in IDLE; counters cleared.
- Index rule: stage s runs 0..N_LOG2-1; butterfly b runs 0..N/2-1.
  - k = (b mod (N/2 >> s)) << s, computed in N_LOG2 bits.
  - Imaginary address = (k + N/4) mod N. The LUT returns cos(2π(k+N/4)/N) = −sin(2πk/N).
- FSM states: IDLE, ISSUE_RE, ISSUE_IM, WAIT, PRESENT.
  - IDLE: start → ISSUE_RE, busy=1.
  - ISSUE_RE: addr=k for one cycle → ISSUE_IM.
  - ISSUE_IM: addr=imag address for one cycle → WAIT.
  - WAIT: Dout captured into tw_re at the end of cycle (ISSUE_RE + LUT_LAT), and into tw_im at the end of cycle (ISSUE_IM + LUT_LAT) → PRESENT.
  - PRESENT: tw_valid=1. tw_re, tw_im, tw_stage, tw_bfly and tw_last are held stable until handshake.
    - Handshake, not last: advance b; on wrap b=N/2-1→0, increment s → ISSUE_RE.
    - Handshake, last (s=N_LOG2-1, b=N/2-1): done=1 next cycle, busy=0 → IDLE.
- addr holds its last value outside the ISSUE states.
- Latency: start in cycle 0 → tw_valid first high in cycle 3+LUT_LAT (cycle 4 for default). With tw_ready held high, one twiddle every 3+LUT_LAT cycles.
- tw_valid never drops without a handshake. tw_ready while tw_valid=0 has no effect.
- start while busy is ignored, including in the done cycle (done and busy=0 appear together; a new start is accepted from the following cycle).
- reset mid-sweep: immediate abort; no done pulse. A later start restarts at s=0, b=0.
- Sweep totals: N_LOG2·N/2 twiddles (2304 for defaults).

Optional Feature:
- Macro TW_FETCH_CONJ_EN.
- Defined: imaginary address = (k + 3N/4) mod N, so tw_im = +sin(2πk/N) (conjugate twiddles for inverse FFT). Everything else unchanged.
- Undefined: forward twiddles as specified above.

Test Plan:
- LUT model with registered ramp (Dout = address, LUT_LAT=1). Pulse start, tw_ready=1 → first tw_valid in cycle 4; s=0,b=3 gives tw_re=3, tw_im=131; consecutive twiddles 4 cycles apart.
- Same model, check s=1,b=130: k=4, tw_re=4, tw_im=132. Check s=8: k=0 for all b, tw_re=0, tw_im=128.
- Full sweep: exactly 2304 handshakes. tw_last only on s=8,b=255. done one cycle after that handshake; busy falls with done.
- Random tw_ready stalls: tw_valid and all tw_* stable while stalled; no twiddle lost or duplicated; sequence identical to the unstalled run.
- Assert reset mid-stage 3: all outputs return to reset values asynchronously, no done. A second start yields first twiddle s=0,b=0, tw_re=0, tw_im=128. A start pulsed mid-sweep is ignored.
- With TW_FETCH_CONJ_EN: s=0,b=3 gives tw_im=387. LUT_LAT=3 build: first tw_valid in cycle 6, values unchanged.
